// File: rtl/audio_resample_out.sv
// Audio output stage: leaky-integrator smoothing, phase-accumulator
// resampling, optional DC blocker and a 2-deep FWFT valid/ready FIFO.
module audio_resample_out #(
   parameter int CLK_HZ   = 7159090,
   parameter int OUT_HZ   = 48000,
   parameter int LP_SHIFT = 4,
   parameter int DC_SHIFT = 10
) (
   input  logic        sysclk_7_143,
   input  logic        reset,
   input  logic        in_ce,
   input  logic [15:0] audio_in,
   input  logic        dc_en,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        overflow
);

   localparam int LW = 16 + LP_SHIFT;

   logic signed [LW-1:0] lp_acc;
   logic signed [LW:0]   x_ext;
   logic signed [LW:0]   acc_ext;
   logic signed [LW-1:0] lp_next;
   logic signed [15:0]   lp_out;

   logic [23:0] phase;
   logic [24:0] phase_sum;
   logic [23:0] phase_next;
   logic        tick;

   logic               v0;
   logic               v1;
   logic signed [15:0] s0;
   logic signed [15:0] s1;
   logic signed [15:0] dc_x_prev;
   logic signed [15:0] dc_y;
   logic signed [15:0] dc_decay;
   logic signed [17:0] dc_sum;
   logic signed [15:0] y;

   logic [15:0] mem [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  count;
   logic [15:0] last;
   logic        pop;
   logic        push_ok;
   logic        drop;

   // x is widened one bit so x - acc cannot wrap before the shift
   always_comb begin
      x_ext   = {audio_in[15], audio_in, {LP_SHIFT{1'b0}}};
      acc_ext = {lp_acc[LW-1], lp_acc};
      lp_next = lp_acc + LW'((x_ext - acc_ext) >>> LP_SHIFT);
      lp_out  = lp_acc[LW-1:LP_SHIFT];
   end

   always_comb begin
      phase_sum  = {1'b0, phase} + 25'(OUT_HZ);
      tick       = phase_sum >= 25'(CLK_HZ);
      phase_next = tick ? 24'(phase_sum - 25'(CLK_HZ))
                        : phase_sum[23:0];
   end

   always_comb begin
      dc_decay = dc_y >>> DC_SHIFT;
      dc_sum   = {{2{s0[15]}}, s0}
               - {{2{dc_x_prev[15]}}, dc_x_prev}
               + {{2{dc_y[15]}}, dc_y}
               - {{2{dc_decay[15]}}, dc_decay};
      y = s0;
      if (dc_en) begin
         if (dc_sum[17:15] == 3'b000 || dc_sum[17:15] == 3'b111)
            y = dc_sum[15:0];
         else if (dc_sum[17])
            y = 16'sh8000;
         else
            y = 16'sh7FFF;
      end
   end

   always_comb begin
      out_valid = count != 2'd0;
      out_data  = out_valid ? mem[rd_ptr] : last;
      pop       = out_valid & out_ready;
      push_ok   = v1 & ((count != 2'd2) | pop);
      drop      = v1 & (count == 2'd2) & ~pop;
   end

   always_ff @(posedge sysclk_7_143) begin
      if (reset) begin
         lp_acc    <= '0;
         phase     <= '0;
         v0        <= 1'b0;
         v1        <= 1'b0;
         s0        <= '0;
         s1        <= '0;
         dc_x_prev <= '0;
         dc_y      <= '0;
         mem[0]    <= '0;
         mem[1]    <= '0;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         count     <= '0;
         last      <= '0;
         overflow  <= 1'b0;
      end else begin
         if (in_ce)
            lp_acc <= lp_next;
         phase <= phase_next;
         v0    <= tick;
         if (tick)
            s0 <= lp_out;
         v1 <= v0;
         if (v0) begin
            s1        <= y;
            dc_x_prev <= s0;
            dc_y      <= dc_en ? y : 16'sd0;
         end
         if (push_ok) begin
            mem[wr_ptr] <= s1;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            last   <= mem[rd_ptr];
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push_ok} - {1'b0, pop};
         if (drop)
            overflow <= 1'b1;
      end
   end

endmodule
